btb_ctrl: RTL and testbench
===========================

Name: btb_ctrl

Overview:
- Controller and storage for the branch target buffer (BTB) in the redirection pipeline.
- IF stage sends a lookup PC each cycle. The block returns hit, predicted-taken and predicted target combinationally.
- EX stage sends resolved-branch updates. The block maintains 2-bit saturating predictors, allocates entries and arbitrates between flush and update.
- Tag comparison and per-entry state are internal; the pipeline sees only the prediction and update interface.

Parameters:
- ENTRIES, 8, number of fully-associative entries (power of 2, 2..32).
- PC_W, 32, PC and target width; tag is PC[PC_W-1:2].
- CNT_W, 16, width of the hit and mispredict statistics counters.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Lookup_PC  in  PC_W  IF-stage fetch PC.
- Pred_Hit  out  1  Lookup_PC matches a valid entry.
- Pred_Taken  out  1  Pred_Hit and the entry counter MSB = 1.
- Pred_Target  out  PC_W  target of the hit entry; 0 on miss.
- Upd_Valid  in  1  EX reports a resolved branch this cycle.
- Upd_PC  in  PC_W  branch instruction PC.
- Upd_Taken  in  1  actual branch outcome.
- Upd_Target  in  PC_W  actual branch target.
- Upd_Mispred  in  1  EX detected a misprediction; increments Mispred_Count.
- Flush_Req  in  1  invalidate all entries.
- Flush_Ack  out  1  pulses one cycle after a flush completes.
- Hit_Count  out  CNT_W  saturating count of lookup hits.
- Mispred_Count  out  CNT_W  saturating count of Upd_Valid & Upd_Mispred.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All valid bits 0, counters 2'b01, targets 0.
  - Replacement pointer 0, Flush_Ack 0, Hit_Count 0, Mispred_Count 0.
  - Pred_* outputs are therefore 0.
- Lookup is purely combinational: zero-cycle latency from Lookup_PC to Pred_*.
  - Tags are unique by construction, so at most one entry matches.
  - Hit_Count increments on each clock edge where Pred_Hit = 1, saturating at all-ones.
- Updates take effect on the rising edge. A lookup in the same cycle sees pre-update contents, with no bypass.
- Update, hit on the Upd_PC tag:
  - Upd_Taken=1: counter increments, saturating at 3; target <= Upd_Target.
  - Upd_Taken=0: counter decrements, saturating at 0; target unchanged.
- Update, miss, Upd_Taken=1: allocate a victim.
  - Victim is the lowest-index invalid entry if any exists.
  - Otherwise the victim is the round-robin pointer, which then advances by 1 mod ENTRIES.
  - New entry: valid=1, tag, target=Upd_Target, counter=2'b10 (weakly taken).
- Update, miss, Upd_Taken=0: no allocation, no state change.
- The pointer advances only when it was used as the victim; an invalid-slot allocation leaves it untouched.
- Flush state machine, states IDLE -> FLUSH -> ACK -> IDLE:
  - IDLE: Flush_Req=1 moves to FLUSH on the next edge.
  - FLUSH: clears every valid bit and the pointer in one edge, then moves to ACK.
  - ACK: Flush_Ack=1 for exactly one cycle, then returns to IDLE.
  - Flush_Req held high in ACK is ignored. A fresh request is accepted only in IDLE.
  - In FLUSH and ACK, Upd_Valid is ignored (dropped) and Pred_Hit is forced to 0.
  - Statistics counters are not cleared by a flush.
- Simultaneous Flush_Req and Upd_Valid in IDLE: the update is performed, then the flush clears it.
- Mispred_Count increments whenever Upd_Valid & Upd_Mispred, including during FLUSH/ACK.
- Reset asserted mid-flush returns to IDLE with Flush_Ack=0.

Decomposition:
- Package btb_pkg holds:
  - The 2-bit counter encodings: SNT=0, WNT=1, WT=2, ST=3.
  - The flush FSM state typedef (IDLE, FLUSH, ACK).
  - The tag-width function PC_W-2.
- Sub-module btb_entry holds one entry (valid, tag, target, counter) plus its match comparator and saturating counter update. btb_ctrl instantiates it ENTRIES times.

Test Plan:
1. Reset, then Lookup_PC=0x00400010 -> Pred_Hit=0, Pred_Target=0, Hit_Count=0.
2. Upd_Valid, Upd_PC=0x00400010, Upd_Taken=1, Upd_Target=0x00400100 -> next cycle a lookup of 0x00400010 gives Hit=1, Taken=1, Target=0x00400100.
3. Two not-taken updates on that PC -> counter 2->1->0, Pred_Taken=0 with Pred_Hit=1. A further not-taken update keeps the counter at 0. Three taken updates saturate it at 3.
4. Allocate 9 distinct taken branches with ENTRIES=8 -> the 9th overwrites entry 0 and the first PC now misses. The 10th overwrites entry 1.
5. Flush_Req=1 together with a taken Upd_Valid -> Flush_Ack high exactly 2 cycles later for 1 cycle, then all lookups miss. Updates presented during FLUSH/ACK leave no entry.
6. Upd_Mispred pulsed 3 times and 5 hit lookups -> Mispred_Count=3, Hit_Count=5. Drive Reset_n low mid-flush -> all counters 0 and Flush_Ack 0 immediately.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared encodings for the branch target buffer: predictor counter values,
// flush state machine states and the tag width derived from the PC width.
package btb_pkg;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACK   = 2'd2
    } flush_state_e;

    // Instructions are word aligned, so PC[1:0] carries no tag information.
    function automatic int tag_width(input int pc_w);
        return pc_w - 2;
    endfunction

endpackage

// File: rtl/btb_entry.sv
// One fully-associative BTB entry: valid/tag/target/2-bit counter, with
// match comparators for the lookup and update ports.
module btb_entry
    import btb_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int TAG_W = tag_width(PC_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_clr,
    input  logic             upd_en,
    input  logic             alloc_en,
    input  logic             upd_taken,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [PC_W-1:0]  upd_target,
    output logic             valid,
    output logic             lookup_hit,
    output logic             upd_hit,
    output logic [PC_W-1:0]  target,
    output logic [1:0]       ctr
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [1:0]       ctr_q, ctr_d;

    assign valid      = valid_q;
    assign target     = target_q;
    assign ctr        = ctr_q;
    assign lookup_hit = valid_q && (tag_q == lookup_tag);
    assign upd_hit    = valid_q && (tag_q == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_clr) begin
            valid_d = 1'b0;
        end else if (alloc_en) begin
            valid_d  = 1'b1;
            tag_d    = upd_tag;
            target_d = upd_target;
            ctr_d    = CNT_WT;
        end else if (upd_en && upd_hit) begin
            // Not-taken outcomes keep the last known target.
            if (upd_taken) begin
                target_d = upd_target;
                ctr_d    = (ctr_q == CNT_ST) ? CNT_ST : ctr_q + 2'd1;
            end else begin
                ctr_d    = (ctr_q == CNT_SNT) ? CNT_SNT : ctr_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= CNT_WNT;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: rtl/btb_ctrl.sv
// Branch target buffer controller: combinational lookup, predictor updates,
// victim allocation, flush sequencing and hit/mispredict statistics.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [PC_W-1:0]  Lookup_PC,
    output logic             Pred_Hit,
    output logic             Pred_Taken,
    output logic [PC_W-1:0]  Pred_Target,
    input  logic             Upd_Valid,
    input  logic [PC_W-1:0]  Upd_PC,
    input  logic             Upd_Taken,
    input  logic [PC_W-1:0]  Upd_Target,
    input  logic             Upd_Mispred,
    input  logic             Flush_Req,
    output logic             Flush_Ack,
    output logic [CNT_W-1:0] Hit_Count,
    output logic [CNT_W-1:0] Mispred_Count,
    output logic [1:0]       Dbg_State
);

    localparam int TAG_W = tag_width(PC_W);
    localparam int IDX_W = $clog2(ENTRIES);

    flush_state_e     state_q, state_d;
    logic             flush_ack_q, flush_ack_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [ENTRIES-1:0] ent_valid, ent_lk_hit, ent_upd_hit, ent_alloc;
    logic [PC_W-1:0]    ent_target [ENTRIES];
    logic [1:0]         ent_ctr    [ENTRIES];

    logic             idle, upd_en, alloc_en, have_inv;
    logic [IDX_W-1:0] first_inv, victim;
    logic [PC_W-1:0]  hit_target;
    logic             hit_taken;
    logic             unused_pc_low;

    assign unused_pc_low = ^{Lookup_PC[1:0], Upd_PC[1:0]};

    assign idle     = (state_q == IDLE);
    assign upd_en   = Upd_Valid && idle;
    assign alloc_en = upd_en && Upd_Taken && !(|ent_upd_hit);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        btb_entry #(.PC_W(PC_W), .TAG_W(TAG_W)) u_entry (
            .clk        (Clock),
            .rst_n      (Reset_n),
            .flush_clr  (state_q == FLUSH),
            .upd_en     (upd_en),
            .alloc_en   (ent_alloc[g]),
            .upd_taken  (Upd_Taken),
            .lookup_tag (Lookup_PC[PC_W-1:2]),
            .upd_tag    (Upd_PC[PC_W-1:2]),
            .upd_target (Upd_Target),
            .valid      (ent_valid[g]),
            .lookup_hit (ent_lk_hit[g]),
            .upd_hit    (ent_upd_hit[g]),
            .target     (ent_target[g]),
            .ctr        (ent_ctr[g])
        );
    end

    // Tags are unique, so OR-ing the matching entry is a one-hot mux.
    always_comb begin
        hit_target = '0;
        hit_taken  = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_lk_hit[i]) begin
                hit_target = hit_target | ent_target[i];
                hit_taken  = hit_taken | ent_ctr[i][1];
            end
        end
    end

    assign Pred_Hit    = idle && (|ent_lk_hit);
    assign Pred_Taken  = Pred_Hit && hit_taken;
    assign Pred_Target = Pred_Hit ? hit_target : '0;

    always_comb begin
        have_inv  = 1'b0;
        first_inv = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                have_inv  = 1'b1;
                first_inv = IDX_W'(i);
            end
        end
        victim = have_inv ? first_inv : ptr_q;
        for (int i = 0; i < ENTRIES; i++) begin
            ent_alloc[i] = alloc_en && (victim == IDX_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_ack_d = 1'b0;
        ptr_d       = ptr_q;
        unique case (state_q)
            IDLE:    if (Flush_Req) state_d = FLUSH;
            FLUSH: begin
                state_d     = ACK;
                flush_ack_d = 1'b1;
                ptr_d       = '0;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The pointer only moves when it actually supplied the victim.
        if (alloc_en && !have_inv) ptr_d = ptr_q + IDX_W'(1);
        hit_cnt_d = (Pred_Hit && hit_cnt_q != '1) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
        mis_cnt_d = (Upd_Valid && Upd_Mispred && mis_cnt_q != '1) ? mis_cnt_q + CNT_W'(1)
                                                                 : mis_cnt_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            flush_ack_q <= 1'b0;
            ptr_q       <= '0;
            hit_cnt_q   <= '0;
            mis_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_ack_q <= flush_ack_d;
            ptr_q       <= ptr_d;
            hit_cnt_q   <= hit_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    assign Flush_Ack     = flush_ack_q;
    assign Hit_Count     = hit_cnt_q;
    assign Mispred_Count = mis_cnt_q;
    assign Dbg_State     = state_q;

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: predictor table vectors plus hand-written
// allocation, flush and reset-during-flush sequences.
module tb_btb_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] Lookup_PC;
    logic        Pred_Hit;
    logic        Pred_Taken;
    logic [31:0] Pred_Target;
    logic        Upd_Valid;
    logic [31:0] Upd_PC;
    logic        Upd_Taken;
    logic [31:0] Upd_Target;
    logic        Upd_Mispred;
    logic        Flush_Req;
    logic        Flush_Ack;
    logic [15:0] Hit_Count;
    logic [15:0] Mispred_Count;
    logic [1:0]  Dbg_State;

    btb_ctrl #(.ENTRIES(8), .PC_W(32), .CNT_W(16)) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Lookup_PC     (Lookup_PC),
        .Pred_Hit      (Pred_Hit),
        .Pred_Taken    (Pred_Taken),
        .Pred_Target   (Pred_Target),
        .Upd_Valid     (Upd_Valid),
        .Upd_PC        (Upd_PC),
        .Upd_Taken     (Upd_Taken),
        .Upd_Target    (Upd_Target),
        .Upd_Mispred   (Upd_Mispred),
        .Flush_Req     (Flush_Req),
        .Flush_Ack     (Flush_Ack),
        .Hit_Count     (Hit_Count),
        .Mispred_Count (Mispred_Count),
        .Dbg_State     (Dbg_State)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        fl;
        logic [31:0] lk;
        logic        eh;
        logic        et;
        logic [31:0] etg;
        logic        ea;
    } vec_t;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] T_A  = 32'h0040_0100;
    localparam logic [31:0] T_B  = 32'h0040_0200;

    vec_t tbl [13];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   exp_hits = 0;
    int   exp_mis  = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic vec_t mkv(input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utg, input logic um, input logic fl,
                                 input logic [31:0] lk, input logic eh, input logic et,
                                 input logic [31:0] etg, input logic ea);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um; v.fl = fl;
        v.lk = lk; v.eh = eh; v.et = et; v.etg = etg; v.ea = ea;
        return v;
    endfunction

    function automatic logic [31:0] pc_b(input int i);
        return 32'h0040_1000 + 32'(i * 16);
    endfunction

    function automatic logic [31:0] tgt_b(input int i);
        return 32'h0050_0000 + 32'(i * 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge and check the pre-edge outputs.
    task automatic apply(input vec_t v, input string nm);
        @(negedge Clock);
        Upd_Valid   = v.uv;
        Upd_PC      = v.upc;
        Upd_Taken   = v.ut;
        Upd_Target  = v.utg;
        Upd_Mispred = v.um;
        Flush_Req   = v.fl;
        Lookup_PC   = v.lk;
        #2;
        chk({nm, ".hit"},    32'(Pred_Hit),    32'(v.eh));
        chk({nm, ".taken"},  32'(Pred_Taken),  32'(v.et));
        chk({nm, ".target"}, Pred_Target,      v.etg);
        chk({nm, ".ack"},    32'(Flush_Ack),   32'(v.ea));
        if (v.eh) exp_hits++;
        if (v.uv && v.um) exp_mis++;
    endtask

    initial begin
        Reset_n     = 1'b0;
        Lookup_PC   = PC_A;
        Upd_Valid   = 1'b0;
        Upd_PC      = '0;
        Upd_Taken   = 1'b0;
        Upd_Target  = '0;
        Upd_Mispred = 1'b0;
        Flush_Req   = 1'b0;

        //            uv upc   ut utg           um fl lk    eh et etg  ea
        tbl[0]  = mkv(0, 0,    0, 0,            0, 0, PC_A, 0, 0, 0,   0);
        tbl[1]  = mkv(1, PC_A, 1, T_A,          1, 0, PC_A, 0, 0, 0,   0);
        tbl[2]  = mkv(0, 0,    0, 0,            1, 0, PC_A, 1, 1, T_A, 0);
        tbl[3]  = mkv(1, PC_A, 0, T_A,          0, 0, PC_A, 1, 1, T_A, 0);
        tbl[4]  = mkv(1, PC_A, 0, 0,            1, 0, PC_A, 1, 0, T_A, 0);
        tbl[5]  = mkv(1, PC_A, 0, 32'hdead_beec, 0, 0, PC_A, 1, 0, T_A, 0);
        tbl[6]  = mkv(1, PC_A, 1, T_A,          0, 0, PC_A, 1, 0, T_A, 0);
        tbl[7]  = mkv(1, PC_A, 1, T_A,          0, 0, PC_A, 1, 0, T_A, 0);
        tbl[8]  = mkv(1, PC_A, 1, T_B,          0, 0, PC_A, 1, 1, T_A, 0);
        tbl[9]  = mkv(1, PC_A, 1, T_A,          0, 0, PC_A, 1, 1, T_B, 0);
        tbl[10] = mkv(1, PC_A, 0, 0,            0, 0, PC_A, 1, 1, T_A, 0);
        tbl[11] = mkv(1, PC_A, 0, 0,            0, 0, PC_A, 1, 1, T_A, 0);
        tbl[12] = mkv(0, 0,    0, 0,            0, 0, PC_A, 1, 0, T_A, 0);

        repeat (3) @(negedge Clock);
        #2;
        chk("rst.hit",    32'(Pred_Hit),  0);
        chk("rst.target", Pred_Target,    0);
        chk("rst.hitcnt", 32'(Hit_Count), 0);
        chk("rst.ack",    32'(Flush_Ack), 0);
        chk("rst.state",  32'(Dbg_State), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        for (int i = 0; i < 13; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Eight more taken branches: seven fill the invalid slots, the eighth
        // evicts entry 0 (PC_A) via the pointer; the ninth evicts entry 1.
        for (int i = 1; i <= 8; i++)
            apply(mkv(1, pc_b(i), 1, tgt_b(i), 0, 0, 0, 0, 0, 0, 0), $sformatf("alloc%0d", i));
        apply(mkv(0, 0, 0, 0, 0, 0, PC_A, 0, 0, 0, 0), "evictA");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(1), 1, 1, tgt_b(1), 0), "keepB1");
        apply(mkv(1, pc_b(9), 1, tgt_b(9), 0, 0, 0, 0, 0, 0, 0), "alloc9");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(1), 0, 0, 0, 0), "evictB1");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(2), 1, 1, tgt_b(2), 0), "keepB2");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(8), 1, 1, tgt_b(8), 0), "keepB8");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(9), 1, 1, tgt_b(9), 0), "hitB9");

        // Flush with a concurrent update; updates in FLUSH/ACK are dropped.
        apply(mkv(1, 32'h0040_2000, 1, 32'h0060_0000, 0, 1, pc_b(2), 1, 1, tgt_b(2), 0), "fl0");
        apply(mkv(1, 32'h0040_2010, 1, 32'h0060_0010, 1, 1, pc_b(2), 0, 0, 0, 0), "fl1");
        apply(mkv(1, 32'h0040_2020, 1, 32'h0060_0020, 1, 1, pc_b(2), 0, 0, 0, 1), "fl2");
        apply(mkv(0, 0, 0, 0, 0, 0, 32'h0040_2000, 0, 0, 0, 0), "fl3");
        apply(mkv(0, 0, 0, 0, 0, 0, 32'h0040_2010, 0, 0, 0, 0), "fl4");
        apply(mkv(0, 0, 0, 0, 0, 0, 32'h0040_2020, 0, 0, 0, 0), "fl5");
        apply(mkv(0, 0, 0, 0, 0, 0, pc_b(2), 0, 0, 0, 0), "fl6");
        apply(mkv(1, 32'h0040_3000, 1, 32'h0070_0000, 0, 0, 0, 0, 0, 0, 0), "fl7");
        apply(mkv(0, 0, 0, 0, 0, 0, 32'h0040_3000, 1, 1, 32'h0070_0000, 0), "fl8");

        @(negedge Clock);
        #2;
        chk("stat.hitcnt", 32'(Hit_Count),     32'(exp_hits));
        chk("stat.miscnt", 32'(Mispred_Count), 32'(exp_mis));

        // Reset while Flush_Ack is high drops everything at once.
        apply(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rf0");
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rf1");
        apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "rf2");
        Reset_n = 1'b0;
        #1;
        chk("rf.ack",    32'(Flush_Ack),     0);
        chk("rf.hitcnt", 32'(Hit_Count),     0);
        chk("rf.miscnt", 32'(Mispred_Count), 0);
        chk("rf.state",  32'(Dbg_State),     0);
        @(negedge Clock);
        Reset_n = 1'b1;
        apply(mkv(1, 32'h0040_4000, 1, 32'h0080_0000, 0, 0, 32'h0040_3000, 0, 0, 0, 0), "post0");
        apply(mkv(0, 0, 0, 0, 0, 0, 32'h0040_4000, 1, 1, 32'h0080_0000, 0), "post1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
